// File: rtl/ex_pkg.sv
// Shared constants for the ID/EX decode-execute slice: opcodes, funct fields,
// operand-mux encodings and bit positions of the 16-bit control bundle.
package ex_pkg;

  localparam int unsigned ILEN   = 32;
  localparam int unsigned CTRL_W = 16;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_MAC    = 7'b0001011
  } opcode_e;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRA     = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_MAC     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // bit0: B takes the immediate, bit1: A takes the PC
  typedef enum logic [1:0] {
    MUX_RR = 2'b00,
    MUX_RI = 2'b01,
    MUX_PI = 2'b11
  } mux_sel_e;

  localparam int unsigned CB_ADD    = 15;
  localparam int unsigned CB_SUB    = 14;
  localparam int unsigned CB_AND    = 13;
  localparam int unsigned CB_OR     = 12;
  localparam int unsigned CB_ADDI   = 11;
  localparam int unsigned CB_SLL    = 10;
  localparam int unsigned CB_SRA    = 9;
  localparam int unsigned CB_BEQ    = 8;
  localparam int unsigned CB_SW     = 7;
  localparam int unsigned CB_LW     = 6;
  localparam int unsigned CB_MAC    = 5;
  localparam int unsigned CB_RD_MEM = 4;
  localparam int unsigned CB_WR_MEM = 3;
  localparam int unsigned CB_WR_RD  = 2;
  localparam int unsigned CB_MUX_HI = 1;
  localparam int unsigned CB_MUX_LO = 0;

endpackage

// File: rtl/ex_stage_alu_ctrl_instr_decoder.sv
// Pure combinational ID-stage decode of a 32-bit instruction into the control bundle.
// MAC_DECODE_EN enables decoding of the custom MAC opcode; otherwise it is a NOP.
module instr_decoder
  import ex_pkg::*;
(
  input  logic [ILEN-1:0]   id_instr,
  output logic [CTRL_W-1:0] id_ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = id_instr[6:0];
  assign funct3        = id_instr[14:12];
  assign funct7        = id_instr[31:25];
  assign unused_fields = ^{id_instr[24:15], id_instr[11:7]};

  always_comb begin
    id_ctrl = '0;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD_SUB: id_ctrl[CB_ADD] = 1'b1;
            F3_AND:     id_ctrl[CB_AND] = 1'b1;
            F3_OR:      id_ctrl[CB_OR]  = 1'b1;
            F3_SLL:     id_ctrl[CB_SLL] = 1'b1;
            default:    ;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            F3_ADD_SUB: id_ctrl[CB_SUB] = 1'b1;
            F3_SRA:     id_ctrl[CB_SRA] = 1'b1;
            default:    ;
          endcase
        end
        // unsupported funct combinations leave the whole bundle as a NOP
        id_ctrl[CB_WR_RD] = |id_ctrl[CB_ADD:CB_MAC];
      end
      OP_IMM: if (funct3 == F3_ADDI) begin
        id_ctrl[CB_ADDI]               = 1'b1;
        id_ctrl[CB_WR_RD]              = 1'b1;
        id_ctrl[CB_MUX_HI:CB_MUX_LO]   = MUX_RI;
      end
      OP_LOAD: if (funct3 == F3_LW) begin
        id_ctrl[CB_LW]                 = 1'b1;
        id_ctrl[CB_RD_MEM]             = 1'b1;
        id_ctrl[CB_WR_RD]              = 1'b1;
        id_ctrl[CB_MUX_HI:CB_MUX_LO]   = MUX_RI;
      end
      OP_STORE: if (funct3 == F3_SW) begin
        id_ctrl[CB_SW]                 = 1'b1;
        id_ctrl[CB_WR_MEM]             = 1'b1;
        id_ctrl[CB_MUX_HI:CB_MUX_LO]   = MUX_RI;
      end
      OP_BRANCH: if (funct3 == F3_BEQ) begin
        id_ctrl[CB_BEQ]                = 1'b1;
        id_ctrl[CB_MUX_HI:CB_MUX_LO]   = MUX_PI;
      end
`ifdef MAC_DECODE_EN
      OP_MAC: if (funct3 == F3_MAC) begin
        id_ctrl[CB_MAC]                = 1'b1;
        id_ctrl[CB_WR_RD]              = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_stage_alu_ctrl.sv
// Decode + execute slice: ID decode, ID/EX control register, EX ALU, EX/MEM result register.
// MAC_DECODE_EN (in instr_decoder) enables the custom MAC opcode decode.
module ex_stage_alu_ctrl
  import ex_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic [ILEN-1:0]     id_instr,
  output logic [CTRL_W-1:0]   id_ctrl,
  output logic [CTRL_W-1:0]   ex_ctrl,
  input  logic [XLEN-1:0]     ex_a,
  input  logic [XLEN-1:0]     ex_b,
  input  logic                ex_branch_taken,
  output logic [XLEN-1:0]     ex_alu_result,
  output logic [XLEN-1:0]     mem_alu_result
);

  logic [CTRL_W-1:0] ex_ctrl_d, ex_ctrl_q;
  logic [XLEN-1:0]   mem_alu_result_d, mem_alu_result_q;
  logic [XLEN-1:0]   sum;

  instr_decoder u_decoder (
    .id_instr (id_instr),
    .id_ctrl  (id_ctrl)
  );

  always_comb begin
    ex_ctrl_d        = id_ctrl;
    mem_alu_result_d = ex_alu_result;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q        <= '0;
      mem_alu_result_q <= '0;
    end else begin
      ex_ctrl_q        <= ex_ctrl_d;
      mem_alu_result_q <= mem_alu_result_d;
    end
  end

  assign sum = ex_a + ex_b;

  // priority chain only matters if several strobes are ever set; mac and NOP yield 0
  always_comb begin
    ex_alu_result = '0;
    if (ex_ctrl_q[CB_ADD])       ex_alu_result = sum;
    else if (ex_ctrl_q[CB_SUB])  ex_alu_result = ex_a - ex_b;
    else if (ex_ctrl_q[CB_ADDI]) ex_alu_result = sum;
    else if (ex_ctrl_q[CB_AND])  ex_alu_result = ex_a & ex_b;
    else if (ex_ctrl_q[CB_OR])   ex_alu_result = ex_a | ex_b;
    else if (ex_ctrl_q[CB_SLL])  ex_alu_result = ex_a << ex_b[4:0];
    else if (ex_ctrl_q[CB_SRA])  ex_alu_result = $unsigned($signed(ex_a) >>> ex_b[4:0]);
    else if (ex_ctrl_q[CB_LW])   ex_alu_result = sum;
    else if (ex_ctrl_q[CB_SW])   ex_alu_result = sum;
    else if (ex_ctrl_q[CB_BEQ])  ex_alu_result = ex_branch_taken ? sum : '0;
  end

  assign ex_ctrl        = ex_ctrl_q;
  assign mem_alu_result = mem_alu_result_q;

endmodule

// File: tb/tb_ex_stage_alu_ctrl.sv
// Self-checking bench for ex_stage_alu_ctrl: directed vector table, async reset sequence,
// and randomized instructions against a mask/match decode model plus arithmetic ALU model.
module tb_ex_stage_alu_ctrl;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [31:0] id_instr;
  logic [15:0] id_ctrl;
  logic [15:0] ex_ctrl;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        ex_branch_taken;
  logic [31:0] ex_alu_result;
  logic [31:0] mem_alu_result;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ex_stage_alu_ctrl #(.XLEN(32)) dut (
    .clock           (clock),
    .rst_n           (rst_n),
    .id_instr        (id_instr),
    .id_ctrl         (id_ctrl),
    .ex_ctrl         (ex_ctrl),
    .ex_a            (ex_a),
    .ex_b            (ex_b),
    .ex_branch_taken (ex_branch_taken),
    .ex_alu_result   (ex_alu_result),
    .mem_alu_result  (mem_alu_result)
  );

  always #5 clock = ~clock;

  // control-bundle values, written out from the strobe list {add..wr_rd,mux_sel}
  localparam logic [15:0] C_ADD  = 16'h8004;
  localparam logic [15:0] C_SUB  = 16'h4004;
  localparam logic [15:0] C_AND  = 16'h2004;
  localparam logic [15:0] C_OR   = 16'h1004;
  localparam logic [15:0] C_ADDI = 16'h0805;
  localparam logic [15:0] C_SLL  = 16'h0404;
  localparam logic [15:0] C_SRA  = 16'h0204;
  localparam logic [15:0] C_BEQ  = 16'h0103;
  localparam logic [15:0] C_SW   = 16'h0089;
  localparam logic [15:0] C_LW   = 16'h0055;
  localparam logic [15:0] C_MAC  = 16'h0024;
`ifdef MAC_DECODE_EN
  localparam logic [15:0] C_MAC_EXP = C_MAC;
`else
  localparam logic [15:0] C_MAC_EXP = 16'h0000;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic        taken;
    logic [15:0] ctrl;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [15:0] ctrl;
  } pat_t;

  vec_t vecs[$];
  pat_t model_pats[$];
  pat_t gen_pats[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model_decode(input logic [31:0] instr);
    foreach (model_pats[i])
      if ((instr & model_pats[i].mask) == model_pats[i].match) return model_pats[i].ctrl;
    return 16'h0000;
  endfunction

  function automatic logic [31:0] model_alu(input logic [15:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input logic t);
    logic signed [31:0] sa;
    logic [4:0] sh;
    sa = a;
    sh = b[4:0];
    if (c[15]) return a + b;
    if (c[14]) return a - b;
    if (c[11]) return a + b;
    if (c[13]) return a & b;
    if (c[12]) return a | b;
    if (c[10]) return a << sh;
    if (c[9])  return sa >>> sh;
    if (c[6])  return a + b;
    if (c[7])  return a + b;
    if (c[8])  return t ? a + b : 32'h0;
    return 32'h0;
  endfunction

  function automatic logic [31:0] gen_instr();
    int unsigned k, idx, n, pos;
    logic [31:0] r, ins;
    k = $urandom_range(0, 9);
    r = $urandom;
    if (k >= 8) return r;
    idx = $urandom_range(0, gen_pats.size() - 1);
    ins = (r & ~gen_pats[idx].mask) | gen_pats[idx].match;
    if (k == 7) begin
      n   = $urandom_range(0, 16);
      pos = (n < 7) ? n : (n < 10) ? n + 5 : n + 15;
      ins = ins ^ (32'h1 << pos);
    end
    return ins;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] cur_instr, new_instr, exp_mem, exp_alu;
    logic [15:0] exp_ex;

    // decode rule table: opcode|funct3|funct7 masks for R-type, opcode|funct3 otherwise
    model_pats.push_back('{32'hFE00707F, 32'h00000033, C_ADD});
    model_pats.push_back('{32'hFE00707F, 32'h40000033, C_SUB});
    model_pats.push_back('{32'hFE00707F, 32'h00007033, C_AND});
    model_pats.push_back('{32'hFE00707F, 32'h00006033, C_OR});
    model_pats.push_back('{32'hFE00707F, 32'h00001033, C_SLL});
    model_pats.push_back('{32'hFE00707F, 32'h40005033, C_SRA});
    model_pats.push_back('{32'h0000707F, 32'h00000013, C_ADDI});
    model_pats.push_back('{32'h0000707F, 32'h00002003, C_LW});
    model_pats.push_back('{32'h0000707F, 32'h00002023, C_SW});
    model_pats.push_back('{32'h0000707F, 32'h00000063, C_BEQ});
`ifdef MAC_DECODE_EN
    model_pats.push_back('{32'h0000707F, 32'h0000000B, C_MAC});
`endif
    gen_pats = model_pats;
`ifndef MAC_DECODE_EN
    gen_pats.push_back('{32'h0000707F, 32'h0000000B, 16'h0000});
`endif

    vecs.push_back('{32'h002081B3, 32'h00000005, 32'h00000007, 1'b0, C_ADD,  32'h0000000C});
    vecs.push_back('{32'h002081B3, 32'hFFFFFFFF, 32'h00000002, 1'b0, C_ADD,  32'h00000001});
    vecs.push_back('{32'h402081B3, 32'h00000000, 32'h00000001, 1'b0, C_SUB,  32'hFFFFFFFF});
    vecs.push_back('{32'h4020D1B3, 32'h80000000, 32'h00000021, 1'b0, C_SRA,  32'hC0000000});
    vecs.push_back('{32'h0020F1B3, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, C_AND,  32'hF000F000});
    vecs.push_back('{32'h0020E1B3, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, C_OR,   32'hFFF0FFF0});
    vecs.push_back('{32'h002091B3, 32'h00000001, 32'hFFFFFFE4, 1'b0, C_SLL,  32'h00000010});
    vecs.push_back('{32'h00508193, 32'h7FFFFFFF, 32'h00000001, 1'b0, C_ADDI, 32'h80000000});
    vecs.push_back('{32'h0000A183, 32'h00000100, 32'h00000008, 1'b0, C_LW,   32'h00000108});
    vecs.push_back('{32'h0020A423, 32'h00000100, 32'h00000008, 1'b0, C_SW,   32'h00000108});
    vecs.push_back('{32'h00208463, 32'h00000020, 32'h00000008, 1'b1, C_BEQ,  32'h00000028});
    vecs.push_back('{32'h00208463, 32'h00000020, 32'h00000008, 1'b0, C_BEQ,  32'h00000000});
    vecs.push_back('{32'h0020818B, 32'h00000003, 32'h00000004, 1'b0, C_MAC_EXP, 32'h00000000});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000003, 32'h00000004, 1'b1, 16'h0000, 32'h00000000});
    vecs.push_back('{32'h00000000, 32'h00000003, 32'h00000004, 1'b1, 16'h0000, 32'h00000000});
    vecs.push_back('{32'h022081B3, 32'h00000003, 32'h00000004, 1'b0, 16'h0000, 32'h00000000});
    vecs.push_back('{32'h0020D1B3, 32'h80000000, 32'h00000001, 1'b0, 16'h0000, 32'h00000000});
    vecs.push_back('{32'h00509193, 32'h00000003, 32'h00000004, 1'b0, 16'h0000, 32'h00000000});

    // load state, then assert reset mid-cycle and expect immediate clearing
    rst_n = 1'b1;
    id_instr = 32'h002081B3;
    ex_a = 32'd5;
    ex_b = 32'd7;
    ex_branch_taken = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("pre_reset_ex_ctrl", {16'h0, ex_ctrl}, {16'h0, C_ADD});
    check("pre_reset_mem", mem_alu_result, 32'd12);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_ex_ctrl", {16'h0, ex_ctrl}, 32'h0);
    check("async_reset_mem", mem_alu_result, 32'h0);
    check("async_reset_alu", ex_alu_result, 32'h0);
    @(posedge clock);
    #1;
    check("held_reset_ex_ctrl", {16'h0, ex_ctrl}, 32'h0);
    check("held_reset_mem", mem_alu_result, 32'h0);
    #3;
    id_instr = 32'h402081B3;
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    check("post_release_ex_ctrl", {16'h0, ex_ctrl}, {16'h0, C_SUB});

    foreach (vecs[i]) begin
      id_instr = vecs[i].instr;
      #1;
      check($sformatf("vec%0d_id_ctrl", i), {16'h0, id_ctrl}, {16'h0, vecs[i].ctrl});
      @(posedge clock);
      #1;
      ex_a = vecs[i].a;
      ex_b = vecs[i].b;
      ex_branch_taken = vecs[i].taken;
      #1;
      check($sformatf("vec%0d_ex_ctrl", i), {16'h0, ex_ctrl}, {16'h0, vecs[i].ctrl});
      check($sformatf("vec%0d_ex_alu", i), ex_alu_result, vecs[i].res);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_mem", i), mem_alu_result, vecs[i].res);
    end

    cur_instr = id_instr;
    exp_mem = 32'h0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clock);
      #1;
      exp_ex = model_decode(cur_instr);
      check("rand_ex_ctrl", {16'h0, ex_ctrl}, {16'h0, exp_ex});
      if (i > 0) check("rand_mem", mem_alu_result, exp_mem);
      new_instr = gen_instr();
      id_instr = new_instr;
      ex_a = $urandom;
      ex_b = $urandom;
      ex_branch_taken = 1'($urandom_range(0, 1));
      #1;
      check("rand_id_ctrl", {16'h0, id_ctrl}, {16'h0, model_decode(new_instr)});
      exp_alu = model_alu(exp_ex, ex_a, ex_b, ex_branch_taken);
      check("rand_ex_alu", ex_alu_result, exp_alu);
      exp_mem = exp_alu;
      cur_instr = new_instr;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage_alu_ctrl.md
Name: ex_stage_alu_ctrl

Overview:
- Decode plus execute slice of the 5-stage RV32I-style pipeline.
- Combinationally decodes the ID-stage instruction into control strobes, registers them into ID/EX, and computes the ALU result in EX from externally muxed operands.
- Registers the ALU result into EX/MEM.
- Sits between the IF/ID kill logic (upstream) and the data memory / writeback muxes (downstream).

Parameters:
- XLEN, 32, datapath width (instruction width is fixed at 32).

Ports:
- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_instr  in  32  instruction in ID (already killed/NOPed upstream)
- id_ctrl  out  16  decoded strobes, combinational: {add,sub,and,or,addi,sll,sra,beq,sw,lw,mac,rd_mem,wr_mem,wr_rd,mux_sel[1:0]}
- ex_ctrl  out  16  same bundle, registered (ID/EX)
- ex_a  in  XLEN  ALU operand A (after forwarding/PC mux)
- ex_b  in  XLEN  ALU operand B (after forwarding/immediate mux)
- ex_branch_taken  in  1  comparator decision for the EX-stage beq
- ex_alu_result  out  XLEN  combinational ALU result (also the branch target)
- mem_alu_result  out  XLEN  registered ALU result (EX/MEM)

Behaviour:
- Decode uses opcode [6:0], funct3 [14:12] and funct7 [31:25].
- R-type 0110011:
  - f3=000, f7=0000000 → add
  - f3=000, f7=0100000 → sub
  - f3=111, f7=0 → and
  - f3=110, f7=0 → or
  - f3=001, f7=0 → sll
  - f3=101, f7=0100000 → sra
  - All R-type: wr_rd=1, mux_sel=00.
- 0010011 f3=000 → addi: wr_rd=1, mux_sel=01.
- 0000011 f3=010 → lw: rd_mem=1, wr_rd=1, mux_sel=01.
- 0100011 f3=010 → sw: wr_mem=1, mux_sel=01.
- 1100011 f3=000 → beq: mux_sel=11 (A=PC, B=immediate).
- 0001011 f3=000 → mac: wr_rd=1, mux_sel=00 (only when the macro below is defined).
- Any other encoding, including all-zero: every strobe 0 and mux_sel=00 (NOP).
- Exactly one operation strobe is high per valid instruction.
- mux_sel encoding: bit0 = B selects immediate; bit1 = A selects PC.
- ID/EX register: ex_ctrl <= id_ctrl on every rising clock. There is no stall or enable; upstream injects NOPs.
- ALU, combinational, operating on ex_ctrl:
  - add, addi, lw, sw → a+b, modulo 2^32.
  - sub → a-b, wrapping.
  - and → a&b; or → a|b.
  - sll → a << b[4:0]; upper bits of b are ignored.
  - sra → arithmetic a >>> b[4:0], sign-filled.
  - beq with ex_branch_taken=1 → a+b (target). beq with ex_branch_taken=0 → 0.
  - mac → 0; the MAC result comes from a separate unit.
  - No strobe → 0.
  - If multiple strobes are ever high, priority is add > sub > addi > and > or > sll > sra > lw > sw > beq.
- EX/MEM register: mem_alu_result <= ex_alu_result every rising clock; one-cycle latency.
- Reset (rst_n low, asynchronous): ex_ctrl=0 and mem_alu_result=0 immediately. id_ctrl and ex_alu_result stay combinational; with ex_ctrl=0, ex_alu_result=0.
- Reset deasserted mid-stream: the first edge after release captures the current id_instr.
- No flags, overflow or carry outputs.

Optional Feature:
- MAC_DECODE_EN defined: opcode 0001011 f3=000 decodes to mac=1, wr_rd=1.
- Undefined: that opcode is illegal, giving an all-zero NOP; the mac bit in id_ctrl and ex_ctrl is constant 0.

Decomposition:
- Package ex_pkg:
  - Opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_MAC).
  - funct3 and funct7 constants.
  - mux_sel encodings.
  - Bit indices of the 16-bit control bundle.
- One sub-module, instr_decoder: the pure combinational id_instr → id_ctrl logic.
- ALU and the pipeline registers stay in the top.

Test Plan:
- Reset: drive rst_n=0 mid-cycle → ex_ctrl=0 and mem_alu_result=0 without waiting for a clock edge.
- add x3,x1,x2 (0x002081B3) → id_ctrl add=1, wr_rd=1, mux_sel=00. Next edge with a=5, b=7 → ex_alu_result=12. Following edge → mem_alu_result=12.
- sub (0x402081B3) with a=0, b=1 → 0xFFFFFFFF. sra (0x4020D1B3) with a=0x80000000, b=0x21 → 0xC0000000 (shift 1).
- lw (0x0000A183), mux_sel=01 with a=0x100, b=0x8 → result 0x108, rd_mem=1, wr_rd=1. sw (0x0020A423) → wr_mem=1, wr_rd=0, result 0x108.
- beq (0x00208463), mux_sel=11 with a=0x20, b=8: ex_branch_taken=1 → 0x28; ex_branch_taken=0 → 0.
- Opcode 0001011: with MAC_DECODE_EN → mac=1, wr_rd=1, result 0. Without → all strobes 0. Illegal 0xFFFFFFFF → all strobes 0.
